// File: rtl/ram32_pkg.sv
// Shared types and constants for the 32-bit word RAM responder and its watchdog.
package ram32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HI,
    ST_GAP,
    ST_LO
  } ram32_state_t;

  localparam logic [31:0]  RAM32_FILL_WORD       = 32'hDEAD_DEAD;
  localparam int unsigned  RAM32_DEFAULT_TIMEOUT = 255;

  // Halfword address of one half of a 32-bit word; the high half sits at the even address.
  function automatic logic [24:0] ram32_half_addr(input logic [23:0] word_idx,
                                                  input logic        lo_half);
    return {word_idx, lo_half};
  endfunction

endpackage

// File: rtl/ram_32_to_16_responder_ack_watchdog.sv
// Loadable down-counter that flags a memory half-access that never gets its ack.
module ack_watchdog
  import ram32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = RAM32_DEFAULT_TIMEOUT
) (
  input  logic clk_sys,
  input  logic reset_l,
  input  logic load,
  input  logic run,
  output logic expired
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC);

      logic [CW-1:0] cnt;

      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk_sys or negedge reset_l) begin
        if (!reset_l) begin
          cnt <= '0;
        end else if (load) begin
          cnt <= RELOAD;
        end else if (run && cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end

      // Fires on the waiting cycle whose decrement would bring the count to zero.
      assign expired = run && (cnt == CW'(1));
    end
  endgenerate

endmodule

// File: rtl/ram_32_to_16_responder.sv
// Responder for the 32-bit word RAM interface: splits each word access into two
// sequential 16-bit req/ack accesses, high half first, with a per-half ack watchdog.
module ram_32_to_16_responder
  import ram32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = RAM32_DEFAULT_TIMEOUT,
  parameter logic [31:0] FILL_WORD   = RAM32_FILL_WORD
) (
  input  logic        clk_sys,
  input  logic        reset_l,
  input  logic        word_rd,
  input  logic        word_wr,
  input  logic [25:0] word_addr,
  input  logic [31:0] word_data,
  output logic [31:0] word_q,
  output logic        word_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err_timeout
);

  ram32_state_t state;
  logic         busy_reg;
  logic         is_wr;
  logic [23:0]  addr_lat;
  logic [15:0]  lo_data;
  logic [15:0]  hold;

  logic accept;
  logic wd_load;
  logic wd_run;
  logic wd_expired;
  logic addr_lsb_unused;

  // Requests are only taken in IDLE; pulses arriving mid-access are dropped.
  assign accept    = (state == ST_IDLE) && (word_rd || word_wr);
  assign word_busy = busy_reg | word_rd | word_wr;

  assign wd_load = accept || (state == ST_GAP);
  assign wd_run  = mem_req && !mem_ack;

  assign addr_lsb_unused = ^word_addr[1:0];

  ack_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_sys (clk_sys),
    .reset_l (reset_l),
    .load    (wd_load),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      state       <= ST_IDLE;
      busy_reg    <= 1'b0;
      is_wr       <= 1'b0;
      addr_lat    <= '0;
      lo_data     <= '0;
      hold        <= '0;
      word_q      <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_lat  <= word_addr[25:2];
            lo_data   <= word_data[15:0];
            is_wr     <= word_wr;
            busy_reg  <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= word_wr;
            mem_addr  <= ram32_half_addr(word_addr[25:2], 1'b0);
            mem_wdata <= word_data[31:16];
            state     <= ST_HI;
          end
        end

        ST_HI: begin
          if (mem_ack) begin
            if (!is_wr) begin
              hold <= mem_rdata;
            end
            mem_req <= 1'b0;
            state   <= ST_GAP;
          end else if (wd_expired) begin
            if (!is_wr) begin
              word_q <= FILL_WORD;
            end
            mem_req     <= 1'b0;
            err_timeout <= 1'b1;
            busy_reg    <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        // One idle cycle on the memory port between the two halves.
        ST_GAP: begin
          mem_req   <= 1'b1;
          mem_addr  <= ram32_half_addr(addr_lat, 1'b1);
          mem_wdata <= lo_data;
          state     <= ST_LO;
        end

        ST_LO: begin
          if (mem_ack) begin
            if (!is_wr) begin
              word_q <= {hold, mem_rdata};
            end
            mem_req  <= 1'b0;
            busy_reg <= 1'b0;
            state    <= ST_IDLE;
          end else if (wd_expired) begin
            if (!is_wr) begin
              word_q <= FILL_WORD;
            end
            mem_req     <= 1'b0;
            err_timeout <= 1'b1;
            busy_reg    <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          mem_req  <= 1'b0;
          busy_reg <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_32_to_16_responder.sv
// Self-checking bench: halfword memory model with configurable ack latency plus
// scoreboard queues of expected memory accesses and read results.
module tb_ram_32_to_16_responder;

  logic        clk_sys = 1'b0;
  logic        reset_l = 1'b0;
  logic        word_rd;
  logic        word_wr;
  logic [25:0] word_addr;
  logic [31:0] word_data;
  logic [31:0] word_q;
  logic        word_busy;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err_timeout;

  int          n_checks = 0;
  int          n_err    = 0;

  logic [63:0] acc_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_q;

  int          lat       = 1;
  bit          ack_off   = 1'b0;
  logic        force_ack = 1'b0;
  logic        model_ack = 1'b0;
  logic [15:0] model_rdata = '0;
  logic [15:0] mem_arr [512];
  bit          mem_init  = 1'b0;
  int          wait_cnt  = 0;
  int          acc_count = 0;
  logic [63:0] mdl_got;

  assign mem_ack   = model_ack | force_ack;
  assign mem_rdata = model_rdata;

  always #5 clk_sys = ~clk_sys;

  ram_32_to_16_responder #(
    .TIMEOUT_CYC (4),
    .FILL_WORD   (32'hDEAD_DEAD)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_l     (reset_l),
    .word_rd     (word_rd),
    .word_wr     (word_wr),
    .word_addr   (word_addr),
    .word_data   (word_data),
    .word_q      (word_q),
    .word_busy   (word_busy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] acc(input logic [24:0] a, input logic we, input logic [15:0] d);
    return {22'd0, a, we, (we ? d : 16'h0000)};
  endfunction

  // Memory model: acks the lat-th waiting cycle, compares every access with the scoreboard.
  always @(negedge clk_sys or negedge reset_l) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem_arr[i] = 16'hA500 ^ 16'(i);
      mem_arr[9'h010] = 16'hCAFE;
      mem_arr[9'h011] = 16'hBEEF;
      mem_init = 1'b1;
    end
    if (!reset_l) begin
      model_ack = 1'b0;
      wait_cnt  = 0;
    end else if (model_ack) begin
      check("gap_after_ack", 64'(mem_req), 64'd0);
      model_ack = 1'b0;
      wait_cnt  = 0;
    end else if (mem_req && !ack_off) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        mdl_got = {22'd0, mem_addr, mem_we, (mem_we ? mem_wdata : 16'h0000)};
        if (acc_q.size() == 0) check("acc_pending", 64'(acc_q.size()), 64'd1);
        else                   check("mem_access", mdl_got, acc_q.pop_front());
        model_rdata = mem_arr[mem_addr[8:0]];
        if (mem_we) mem_arr[mem_addr[8:0]] = mem_wdata;
        model_ack = 1'b1;
        acc_count++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Called at a negedge with word_busy low; returns at the first negedge busy is low again.
  task automatic run_access(input logic rd, input logic wr, input logic [25:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_rd,
                            input int intrude_at);
    int cyc;
    bit done;
    acc_q.push_back(acc({addr[25:2], 1'b0}, wr, data[31:16]));
    acc_q.push_back(acc({addr[25:2], 1'b1}, wr, data[15:0]));
    if (!wr) rd_q.push_back(exp_rd);
    // NOTE: bench inputs use blocking assignments, changed half a cycle away from the active edge.
    word_rd   = rd;
    word_wr   = wr;
    word_addr = addr;
    word_data = data;
    #1 check("busy_req_cycle", 64'(word_busy), 64'd1);
    cyc  = 1;
    done = 1'b0;
    @(posedge clk_sys);
    #1 word_rd = 1'b0;
    word_wr = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_sys);
      if (!word_busy) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (cyc == intrude_at) begin
          word_wr   = 1'b1;
          word_addr = 26'h80;
          word_data = 32'h9999_7777;
          @(posedge clk_sys);
          #1 word_wr = 1'b0;
        end
      end
    end
    check("busy_done", 64'(done), 64'd1);
    check("busy_cycles", 64'(cyc), 64'(2 * lat + 2));
    if (!wr && rd_q.size() != 0) exp_q = rd_q.pop_front();
    check("word_q", 64'(word_q), 64'(exp_q));
  endtask

  logic [25:0] bb_addr [5];
  logic [31:0] bb_exp  [5];

  initial begin
    int n0;
    int req_cyc;
    bit found;
    word_rd   = 1'b0;
    word_wr   = 1'b0;
    word_addr = '0;
    word_data = '0;
    exp_q     = '0;
    reset_l   = 1'b0;
    repeat (3) @(negedge clk_sys);

    check("rst_word_q",  64'(word_q),      64'd0);
    check("rst_mem_req", 64'(mem_req),     64'd0);
    check("rst_mem_we",  64'(mem_we),      64'd0);
    check("rst_mem_addr", 64'(mem_addr),   64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_err",     64'(err_timeout), 64'd0);
    check("rst_busy",    64'(word_busy),   64'd0);
    reset_l = 1'b1;
    @(negedge clk_sys);

    // Write, L=1: halves (0x82,1234) then (0x83,ABCD), busy 4 cycles.
    lat = 1;
    run_access(1'b0, 1'b1, 26'h0000_104, 32'h1234_ABCD, 32'h0, 0);

    // Read, L=3: CAFE_BEEF after 8 busy cycles.
    lat = 3;
    run_access(1'b1, 1'b0, 26'h20, 32'h0, 32'hCAFE_BEEF, 0);

    // Simultaneous rd+wr is a write.
    lat = 1;
    run_access(1'b1, 1'b1, 26'h40, 32'h5555_AAAA, 32'h0, 0);

    // Second write mid-access is ignored: exactly two memory accesses.
    n0 = acc_count;
    run_access(1'b0, 1'b1, 26'h0C, 32'h0F0F_F0F0, 32'h0, 3);
    check("intrude_acc_count", 64'(acc_count - n0), 64'd2);

    // Timeout: memory never acks.
    ack_off   = 1'b1;
    word_rd   = 1'b1;
    word_addr = 26'h20;
    #1 check("to_busy_req", 64'(word_busy), 64'd1);
    @(posedge clk_sys);
    #1 word_rd = 1'b0;
    req_cyc = 0;
    found   = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_sys);
      if (mem_req) req_cyc++;
      else         found = 1'b1;
    end
    check("to_req_cycles", 64'(req_cyc), 64'd4);
    check("to_err",    64'(err_timeout), 64'd1);
    check("to_word_q", 64'(word_q),      64'h0000_0000_DEAD_DEAD);
    check("to_busy",   64'(word_busy),   64'd0);
    exp_q   = 32'hDEAD_DEAD;
    ack_off = 1'b0;
    run_access(1'b1, 1'b0, 26'h20, 32'h0, 32'hCAFE_BEEF, 0);
    check("to_err_sticky", 64'(err_timeout), 64'd1);

    // Reset during LO of a read.
    lat = 3;
    acc_q.push_back(acc(25'h82, 1'b0, 16'h0));
    acc_q.push_back(acc(25'h83, 1'b0, 16'h0));
    word_rd   = 1'b1;
    word_addr = 26'h104;
    @(posedge clk_sys);
    #1 word_rd = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_sys);
      if (mem_req && mem_addr[0]) found = 1'b1;
    end
    check("lo_reached", 64'(found), 64'd1);
    #2 reset_l = 1'b0;
    #1 check("rst_lo_mem_req", 64'(mem_req), 64'd0);
    check("rst_lo_word_q", 64'(word_q),      64'd0);
    check("rst_lo_busy",   64'(word_busy),   64'd0);
    check("rst_lo_err",    64'(err_timeout), 64'd0);
    acc_q.delete();
    rd_q.delete();
    exp_q = '0;
    n0 = acc_count;
    @(negedge clk_sys);
    reset_l   = 1'b1;
    force_ack = 1'b1;
    @(negedge clk_sys);
    force_ack = 1'b0;
    req_cyc = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (mem_req) req_cyc++;
    end
    check("late_ack_no_req", 64'(req_cyc), 64'd0);
    check("late_ack_no_acc", 64'(acc_count - n0), 64'd0);
    check("late_ack_word_q", 64'(word_q), 64'd0);

    // Back-to-back reads, L=2, each issued on the first non-busy cycle.
    lat = 2;
    bb_addr[0] = 26'h20;  bb_exp[0] = 32'hCAFE_BEEF;
    bb_addr[1] = 26'h104; bb_exp[1] = 32'h1234_ABCD;
    bb_addr[2] = 26'h40;  bb_exp[2] = 32'h5555_AAAA;
    bb_addr[3] = 26'h80;  bb_exp[3] = 32'hA540_A541;
    bb_addr[4] = 26'h0C;  bb_exp[4] = 32'h0F0F_F0F0;
    for (int k = 0; k < 5; k++) begin
      run_access(1'b1, 1'b0, bb_addr[k], 32'h0, bb_exp[k], 0);
    end

    repeat (3) @(negedge clk_sys);
    check("acc_q_drained", 64'(acc_q.size()), 64'd0);
    check("rd_q_drained",  64'(rd_q.size()),  64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_32_to_16_responder.md
# ram_32_to_16_responder

Responder end of the 32-bit word RAM interface (`word_rd`/`word_wr`/`word_addr`/`word_data`/`word_q`/`word_busy`) driven by the bridge-side 32-bit state controller. Each 32-bit access is split into two sequential 16-bit accesses on a req/ack memory port feeding the cart SDRAM/PSRAM controller. A read result is returned as one 32-bit word. A watchdog aborts accesses that never receive an ack.

## Interface
- `TIMEOUT_CYC`, default 255: cycles to wait for `mem_ack` per half-access; 0 disables the watchdog.
- `FILL_WORD`, default 32'hDEAD_DEAD: value loaded into `word_q` on a read timeout.

Ports:
- `clk_sys` in 1: sole clock.
- `reset_l` in 1: reset, asynchronous, active-low.
- `word_rd` in 1: one-cycle read request pulse.
- `word_wr` in 1: one-cycle write request pulse.
- `word_addr` in 26: byte address; bits [1:0] ignored (32-bit aligned).
- `word_data` in 32: write data, sampled with `word_wr`.
- `word_q` out 32: read data, valid once `word_busy` falls after a read.
- `word_busy` out 1: access in progress.
- `mem_req` out 1: memory request level, held until ack.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` out 25: 16-bit halfword address.
- `mem_wdata` out 16: halfword write data.
- `mem_rdata` in 16: halfword read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: one-cycle completion pulse.
- `err_timeout` out 1: sticky watchdog flag, cleared only by reset.

## Operation
- States: IDLE, HI, GAP, LO.
- IDLE:
  - On `word_wr` or `word_rd`, latch `word_addr[25:2]`, `word_data` and the direction, then go to HI.
  - `word_wr` wins if both are high in the same cycle; the access is treated as a write.
- HI:
  - Drive `mem_req`=1, `mem_addr`={A,1'b0}, `mem_wdata`=data[31:16].
  - On `mem_ack`: for a read, capture `mem_rdata` into a hold register; drop `mem_req`; go to GAP.
- GAP: one cycle with `mem_req`=0, then go to LO.
- LO:
  - Drive `mem_req`=1, `mem_addr`={A,1'b1}, `mem_wdata`=data[15:0].
  - On `mem_ack`: for a read, `word_q` <= {hold, `mem_rdata`}; drop `mem_req`; clear the busy register; go to IDLE.
- Halfword order is high halfword first, at the even address. No byte swapping; the bridge side already handles endianness.
- `word_busy` = busy_reg | `word_rd` | `word_wr`. It is combinational so that the requester, sampling busy one cycle after its pulse, already sees 1.
- `word_q` changes only at completion of a read or on a read timeout. It is unchanged by writes.
- `word_rd`/`word_wr` arriving while busy_reg=1 is a protocol violation and is ignored; the in-flight access is unaffected.
- `mem_ack` while `mem_req`=0 is ignored.
- Watchdog:
  - A counter reloads on entry to HI and to LO, and decrements each cycle `mem_req`=1 without `mem_ack`.
  - On reaching 0 while waiting: drop `mem_req`, set `err_timeout`, go to IDLE, clear busy_reg. For a read, `word_q` <= `FILL_WORD`.

## Timing
- Reset values: `word_q`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err_timeout`=0, busy_reg=0, state IDLE. `word_busy` then reflects only the inputs.
- Reset mid-access forces IDLE at once; `mem_req` falls asynchronously. A pending memory ack after reset is ignored.
- Edge timeline (request pulse high before edge E0):
  - E0 enters HI, and `mem_req` is high after E0.
  - With an ack latency of L cycles per half (ack seen L cycles after `mem_req` rises, L≥1): hi ack at edge E0+L, GAP, LO entered at E0+L+1, lo ack at E0+2L+1.
  - `word_busy` falls after edge E0+2L+1, and `word_q` is valid from then.
  - Minimum busy window (L=1): 4 cycles, including the request cycle.
- `mem_req` is never high for two consecutive halves without the GAP cycle.
- A new request is accepted in the first cycle `word_busy` reads 0 (back-to-back allowed).

## Structure
- Shared package `ram32_pkg`:
  - state enum (IDLE/HI/GAP/LO);
  - `RAM32_FILL_WORD` constant;
  - `RAM32_DEFAULT_TIMEOUT` constant.
- Sub-module `ack_watchdog`: loadable down-counter with `load`, `run` and `expired` ports, parameterised by `TIMEOUT_CYC`. Tie `expired` low when `TIMEOUT_CYC`=0.
- Everything else lives in a single module of about 200 lines.

## Test plan
- Write: `word_wr` with addr 26'h0000_104, data 32'h1234_ABCD, memory model L=1 → halfword accesses (25'h82, we=1, 16'h1234) then (25'h83, we=1, 16'hABCD). `word_busy` high exactly 4 cycles; `word_q` unchanged.
- Read: memory at halfwords 0x10/0x11 = 16'hCAFE/16'hBEEF, `word_rd` at addr 26'h20, L=3 → `word_q`=32'hCAFE_BEEF when `word_busy` falls 8 cycles after the request cycle. `word_busy` is already 1 in the request cycle.
- Simultaneous `word_rd` and `word_wr` → write performed, `word_q` unchanged. A second `word_wr` mid-access → ignored; exactly 2 memory accesses occur.
- Timeout with `TIMEOUT_CYC`=4: read with the memory never acking → `mem_req` high 4 cycles, then low; `err_timeout`=1, `word_q`=32'hDEAD_DEAD, `word_busy`=0. The next read still completes normally and `err_timeout` stays 1.
- Reset during LO of a read → `mem_req`=0 immediately, `word_q`=0. A late `mem_ack` is ignored and no spurious access follows.
- Back-to-back reads issued on the first non-busy cycle → both return the correct data, with a GAP cycle between every pair of halves.
